gshare_pht: RTL and testbench

- Next-generation direction predictor for the BPU. Generalises the bimodal 2-bit table to parametrised N-bit saturating counters.
- Index is formed from PC bits XOR a global history register (GHR). The GHR is updated speculatively at lookup and repaired on mispredict.
- Updates are applied through a 2-stage read-modify-write pipeline with forwarding.
- Sits between fetch (lookup) and the branch-resolve stage in EX (update).

---
 rtl/bpu_pkg.sv | 39 +++
 rtl/gshare_ghr.sv | 41 ++++
 rtl/gshare_pht.sv | 90 +++++++++
 tb/tb_gshare_pht.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared branch-predictor types and helpers: saturating counter arithmetic and
// history shifting, written width-generic so every table geometry can reuse them.
package bpu_pkg;

    localparam int unsigned CTR_W_DEF = 2;
    localparam int unsigned CTR_MAX_W = 16;
    localparam int unsigned GHR_MAX_W = 32;

    typedef logic [CTR_W_DEF-1:0] ctr_t;
    typedef logic [CTR_MAX_W-1:0] ctr_wide_t;
    typedef logic [GHR_MAX_W-1:0] ghr_wide_t;

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic ctr_wide_t ctr_init(input int unsigned w);
        return (ctr_wide_t'(1) << (w - 1)) - ctr_wide_t'(1);
    endfunction

    function automatic ctr_wide_t ctr_next(input ctr_wide_t ctr, input logic taken,
                                           input int unsigned w);
        ctr_wide_t max_v;
        max_v = (ctr_wide_t'(1) << w) - ctr_wide_t'(1);
        if (taken) begin
            return (ctr == max_v) ? ctr : ctr + ctr_wide_t'(1);
        end
        return (ctr == '0) ? ctr : ctr - ctr_wide_t'(1);
    endfunction

    function automatic logic ctr_taken(input ctr_wide_t ctr, input int unsigned w);
        return ctr[w-1];
    endfunction

    function automatic ghr_wide_t ghr_shift(input ghr_wide_t ghr, input logic in_bit,
                                            input int unsigned w);
        ghr_wide_t mask;
        mask = (w >= GHR_MAX_W) ? '1 : (ghr_wide_t'(1) << w) - ghr_wide_t'(1);
        return {ghr[GHR_MAX_W-2:0], in_bit} & mask;
    endfunction

endpackage

// File: rtl/gshare_ghr.sv
// Global history register: speculative shift on lookup, checkpoint-based repair
// on mispredict; repair wins over a same-cycle lookup.
module gshare_ghr
    import bpu_pkg::*;
#(
    parameter int unsigned GHR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             lookup_valid_i,
    input  logic             pred_taken_i,
    input  logic             update_valid_i,
    input  logic             update_mispredict_i,
    input  logic             update_taken_i,
    input  logic [GHR_W-1:0] update_ghr_i,
    output logic [GHR_W-1:0] ghr_o
);

    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (update_valid_i && update_mispredict_i) begin
            ghr_d = GHR_W'(ghr_shift(ghr_wide_t'(update_ghr_i), update_taken_i, GHR_W));
        end else if (lookup_valid_i) begin
            ghr_d = GHR_W'(ghr_shift(ghr_wide_t'(ghr_q), pred_taken_i, GHR_W));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_o = ghr_q;

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: PC^GHR indexed N-bit saturating counters with a
// two-stage read-modify-write update pipeline.
module gshare_pht
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned GHR_W  = 8,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned PC_LSB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_index,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             update_valid,
    input  logic [IDX_W-1:0] update_index,
    input  logic             update_taken,
    input  logic             update_mispredict,
    input  logic [GHR_W-1:0] update_ghr
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [CTR_W-1:0] ctr_q [DEPTH];
    logic [GHR_W-1:0] ghr;

    logic             s1_valid_q;
    logic [IDX_W-1:0] s1_index_q;
    logic             s1_taken_q;
    logic [CTR_W-1:0] s1_rdata_q;
    logic [CTR_W-1:0] s1_rdata_d;
    logic [CTR_W-1:0] s2_wdata;
    logic             unused_pc;

    gshare_ghr #(
        .GHR_W(GHR_W)
    ) u_ghr (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .lookup_valid_i     (lookup_valid),
        .pred_taken_i       (pred_taken),
        .update_valid_i     (update_valid),
        .update_mispredict_i(update_mispredict),
        .update_taken_i     (update_taken),
        .update_ghr_i       (update_ghr),
        .ghr_o              (ghr)
    );

    assign pred_index = lookup_pc[PC_LSB +: IDX_W] ^ IDX_W'(ghr);
    assign pred_taken = ctr_taken(ctr_wide_t'(ctr_q[pred_index]), CTR_W);
    assign pred_ghr   = ghr;
    assign unused_pc  = ^lookup_pc;

    // The counter is read when S1 captures, so an S2 write landing on that same
    // edge for the same index must be forwarded instead of the stale array value.
    assign s2_wdata   = CTR_W'(ctr_next(ctr_wide_t'(s1_rdata_q), s1_taken_q, CTR_W));
    assign s1_rdata_d = (s1_valid_q && (s1_index_q == update_index)) ? s2_wdata
                                                                      : ctr_q[update_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            s1_taken_q <= 1'b0;
            s1_rdata_q <= '0;
        end else begin
            s1_valid_q <= update_valid;
            if (update_valid) begin
                s1_index_q <= update_index;
                s1_taken_q <= update_taken;
                s1_rdata_q <= s1_rdata_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_q[IDX_W'(i)] <= CTR_W'(ctr_init(CTR_W));
            end
        end else if (s1_valid_q) begin
            ctr_q[s1_index_q] <= s2_wdata;
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht: stimulus pushes expected lookup responses,
// a negedge monitor pops and compares whenever a lookup is presented.
module tb_gshare_pht;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [7:0]  pred_index;
    logic [7:0]  pred_ghr;
    logic        update_valid;
    logic [7:0]  update_index;
    logic        update_taken;
    logic        update_mispredict;
    logic [7:0]  update_ghr;

    typedef struct {
        string      nm;
        logic       taken;
        logic [7:0] idx;
        logic [7:0] ghr;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] mg    = 8'h00;

    gshare_pht dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .pred_ghr         (pred_ghr),
        .update_valid     (update_valid),
        .update_index     (update_index),
        .update_taken     (update_taken),
        .update_mispredict(update_mispredict),
        .update_ghr       (update_ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lookup_valid) begin
            exp_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_lookup: got taken=%0b idx=%02h ghr=%02h, none expected",
                         pred_taken, pred_index, pred_ghr);
            end else begin
                e = exp_q.pop_front();
                if ({pred_taken, pred_index, pred_ghr} !== {e.taken, e.idx, e.ghr}) begin
                    bad++;
                    $display("FAIL %s: got taken=%0b idx=%02h ghr=%02h, want taken=%0b idx=%02h ghr=%02h",
                             e.nm, pred_taken, pred_index, pred_ghr, e.taken, e.idx, e.ghr);
                end
            end
        end
    end

    task automatic step(input bit lv, input logic [31:0] pc, input logic et,
                        input logic [7:0] ei, input bit uv, input logic [7:0] ui,
                        input logic ut, input logic um, input logic [7:0] ug,
                        input string nm);
        exp_t e;
        lookup_valid      = lv;
        lookup_pc         = pc;
        update_valid      = uv;
        update_index      = ui;
        update_taken      = ut;
        update_mispredict = um;
        update_ghr        = ug;
        if (lv) begin
            e.nm = nm; e.taken = et; e.idx = ei; e.ghr = mg;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        lookup_valid      = 1'b0;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        if (uv && um)  mg = {ug[6:0], ut};
        else if (lv)   mg = {mg[6:0], et};
    endtask

    task automatic look(input logic [7:0] idx, input logic et, input string nm);
        logic [31:0] pc;
        pc = 32'(idx ^ mg) << 2;
        step(1'b1, pc, et, idx, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, nm);
    endtask

    task automatic upd(input logic [7:0] idx, input logic t);
        step(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, idx, t, 1'b0, 8'h00, "");
    endtask

    task automatic repair(input logic [7:0] idx, input logic t, input logic [7:0] g);
        step(1'b0, 32'h0, 1'b0, 8'h00, 1'b1, idx, t, 1'b1, g, "");
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sat_t  [5];
        logic sat_nt [5];
        sat_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        sat_nt = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        lookup_valid = 1'b0; lookup_pc = '0;
        update_valid = 1'b0; update_index = '0; update_taken = 1'b0;
        update_mispredict = 1'b0; update_ghr = '0;
        @(posedge clk);
        #1;
        step(1'b1, 32'h48, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "reset_state");
        rst_n = 1'b1;

        // Taken update to 0x56 sits in S1 when reset hits; it must be discarded.
        upd(8'h56, 1'b1);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 256; i++) look(8'(i), 1'b0, "reset_sweep");

        for (int k = 0; k < 5; k++) begin
            upd(8'h12, 1'b1); idle(); look(8'h12, sat_t[k], "sat_taken");
        end
        for (int k = 0; k < 5; k++) begin
            upd(8'h12, 1'b0); idle(); look(8'h12, sat_nt[k], "sat_nottaken");
        end

        upd(8'h34, 1'b1);
        step(1'b1, 32'(8'h34 ^ mg) << 2, 1'b0, 8'h34, 1'b1, 8'h34, 1'b1, 1'b0, 8'h00, "fwd_t1");
        look(8'h34, 1'b1, "fwd_t2");
        look(8'h34, 1'b1, "fwd_t3");
        upd(8'h34, 1'b0); idle();
        look(8'h34, 1'b1, "fwd_from_11");

        repair(8'hEE, 1'b0, 8'h00);
        look(8'h34, 1'b1, "ghr_spec_0");
        look(8'h12, 1'b0, "ghr_spec_1");
        look(8'h34, 1'b1, "ghr_spec_2");

        step(1'b1, 32'(8'h34 ^ 8'h05) << 2, 1'b1, 8'h34, 1'b1, 8'hEE, 1'b1, 1'b1, 8'h0A,
             "repair_same_cycle");
        look(8'h12, 1'b0, "repair_result");

        repair(8'hEE, 1'b1, 8'h7F);
        step(1'b1, 32'h0000_0400, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "index_ghr_ff");
        repair(8'hEE, 1'b0, 8'h00);
        step(1'b1, 32'h0000_0400, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "index_ghr_00");

        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
